multi_cycle_mul: RTL and testbench
==================================

Name: multi_cycle_mul

Overview:
Iterative radix-4 Booth multiplier for the RV64M multiply group (MUL, MULH, MULHSU, MULHU, MULW). It is the multiplicative counterpart to the execute-stage multi-cycle divider and uses the same valid/ready contract towards the execute stage. It produces the full 128-bit product; the execute stage selects the high or low half and sign-extends for MULW. It retires one Booth digit per cycle.

Parameters:
XLEN, 64, operand width; product width is 2*XLEN.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  reset; synchronous to clk, active-high.
valid  input  1  operation request; held high by execute stage until the cycle ready is seen.
rs1_signed  input  1  treat rs1 as two's-complement.
rs2_signed  input  1  treat rs2 as two's-complement.
mul_32  input  1  word op: use rs1[31:0] and rs2[31:0], extended by the signed flags.
rs1_data  input  XLEN  multiplicand.
rs2_data  input  XLEN  multiplier.
ready  output  1  one-cycle pulse; mul_result is valid in this cycle.
mul_result  output  2*XLEN  full product {hi, lo}.

Behaviour:
- Operand extension: each operand becomes XLEN+2 bits (66 bits). The fill bit is (signed flag AND operand MSB). When mul_32 is set, the MSB is bit 31 and the fill covers bits 65:32.
- Booth encoding: 33 digits from multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0. Each digit is in {-2,-1,0,+1,+2} times the multiplicand.
- Accumulator: 134 bits, with arithmetic shift right by 2 per step. mul_result equals the low 128 bits of the exact product of the two extended operands.
- States: IDLE, BUSY, DONE. The encoding is free; an internal counter runs 0..32.
- IDLE:
  - ready=0.
  - On valid=1: latch the extended operands and clear the accumulator and counter.
  - If either extended operand is zero, go to DONE directly (zero early-out). The accumulator stays 0.
  - Otherwise go to BUSY.
- BUSY:
  - Each edge with valid=1 applies one Booth digit and increments the counter.
  - On the edge that applies digit 32 (the 33rd step), go to DONE.
  - valid=0 in BUSY means abort: go to IDLE and clear counter and accumulator. No ready is produced.
- DONE:
  - ready=1 and mul_result holds the product for exactly this cycle.
  - The next edge returns to IDLE unconditionally, whatever valid is.
- Latency, counted from the accepting edge in IDLE:
  - normal operation: ready is high in the cycle after 33 BUSY edges, i.e. 34 cycles after acceptance.
  - zero early-out: ready is high in the cycle immediately after acceptance.
- Back-to-back: the execute stage drops valid the cycle after ready. If valid stays high, the next IDLE cycle accepts a new operation using the current rs data.
- Operand inputs are ignored after acceptance; only the latched copies are used.
- mul_result outside DONE: it holds the accumulator low 128 bits and has no meaning; the verifier checks it only when ready=1.
- Reset:
  - rst=1 at any edge forces IDLE, counter=0, accumulator=0, ready=0, mul_result=0.
  - Reset mid-operation discards the operation. rst has priority over valid.
- No overflow or exception conditions exist. Signed × signed of the most negative value is exact in 128 bits.

Test Plan:
- MULHU: rs1=rs2=0xFFFF_FFFF_FFFF_FFFF, both unsigned -> after 34 cycles ready pulses 1 cycle, mul_result=0xFFFFFFFFFFFFFFFE_0000000000000001.
- MUL/MULH: both signed, rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> mul_result=0x0000000000000000_0000000000000001. Also rs1=rs2=0x8000_0000_0000_0000 -> hi=0x4000_0000_0000_0000, lo=0.
- MULHSU: rs1=0xFFFF_FFFF_FFFF_FFFF signed, rs2=0xFFFF_FFFF_FFFF_FFFF unsigned -> mul_result=0xFFFFFFFFFFFFFFFF_0000000000000001.
- MULW: mul_32=1, both signed, rs1=0xDEAD_BEEF_8000_0000, rs2=0x1234_5678_0000_0002 -> lo=0xFFFF_FFFF_0000_0000, hi=all ones; upper input bits have no effect.
- Zero early-out: rs2=0, rs1=0x1234 -> ready in the cycle after acceptance, mul_result=0. Then drop valid -> IDLE, ready=0.
- Abort and reset: start 3×5, drop valid after 10 BUSY cycles -> no ready, next request 7×6 returns 42 at 34 cycles. Separately, assert rst at cycle 20 of an operation -> ready stays 0 and mul_result=0 the cycle after.

Source files
------------

// File: rtl/multi_cycle_mul_if.sv
// Request/response bundle between the execute stage (master) and the
// iterative multiplier (slave).
interface multi_cycle_mul_if #(
   parameter int XLEN = 64
);
   logic              valid;
   logic              rs1_signed;
   logic              rs2_signed;
   logic              mul_32;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic              ready;
   logic [2*XLEN-1:0] mul_result;

   modport master (
      output valid, rs1_signed, rs2_signed, mul_32, rs1_data, rs2_data,
      input  ready, mul_result
   );

   modport slave (
      input  valid, rs1_signed, rs2_signed, mul_32, rs1_data, rs2_data,
      output ready, mul_result
   );
endinterface

// File: rtl/multi_cycle_mul.sv
// Iterative radix-4 Booth multiplier for the RV64M multiply group.
// Retires one Booth digit per cycle and returns the full 2*XLEN product.
module multi_cycle_mul #(
   parameter int XLEN = 64
) (
   input logic              clk,
   input logic              rst,
   multi_cycle_mul_if.slave bus
);
   localparam int EXT  = XLEN + 2;
   localparam int PPW  = EXT + 2;
   localparam int ACC  = 2 * EXT + 2;
   localparam int HALF = XLEN / 2;
   localparam int CNTW = 6;
   localparam int LAST = EXT / 2 - 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [EXT-1:0]  mcand;
   logic [EXT:0]    mplier;
   logic [ACC-1:0]  acc;
   logic [CNTW-1:0] count;
   logic            ready_q;

   logic [EXT-1:0]  rs1_ext;
   logic [EXT-1:0]  rs2_ext;
   logic [PPW-1:0]  mcand_sx;
   logic [PPW-1:0]  pp;
   logic [ACC-1:0]  acc_sum;
   logic [ACC-1:0]  acc_next;

   // Word ops take the low half and extend from bit HALF-1 instead of XLEN-1.
   function automatic logic [EXT-1:0] extend_op(input logic [XLEN-1:0] op,
                                                input logic is_signed,
                                                input logic word);
      logic [EXT-1:0] ext;
      logic           fill;
      if (word) begin
         fill = is_signed & op[HALF-1];
         ext  = {{(EXT-HALF){fill}}, op[HALF-1:0]};
      end else begin
         fill = is_signed & op[XLEN-1];
         ext  = {{(EXT-XLEN){fill}}, op};
      end
      return ext;
   endfunction

   always_comb begin
      rs1_ext = extend_op(bus.rs1_data, bus.rs1_signed, bus.mul_32);
      rs2_ext = extend_op(bus.rs2_data, bus.rs2_signed, bus.mul_32);
   end

   // The multiplier register carries an implicit b[-1]=0 in its LSB, so the
   // current Booth triplet is always mplier[2:0].
   always_comb begin
      mcand_sx = {{2{mcand[EXT-1]}}, mcand};
      pp       = '0;
      case (mplier[2:0])
         3'b001, 3'b010: pp = mcand_sx;
         3'b011:         pp = mcand_sx << 1;
         3'b100:         pp = -(mcand_sx << 1);
         3'b101, 3'b110: pp = -mcand_sx;
         default:        pp = '0;
      endcase
      acc_sum  = acc + {pp, {(ACC-PPW){1'b0}}};
      acc_next = {{2{acc_sum[ACC-1]}}, acc_sum[ACC-1:2]};
   end

   // Partial products enter at the top of the accumulator and slide down two
   // bits per step, so after the last digit the product sits at bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready_q <= 1'b0;
               if (bus.valid) begin
                  mcand  <= rs1_ext;
                  mplier <= {rs2_ext, 1'b0};
                  acc    <= '0;
                  count  <= '0;
                  if (rs1_ext == '0 || rs2_ext == '0) begin
                     state   <= DONE;
                     ready_q <= 1'b1;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (bus.valid) begin
                  acc    <= acc_next;
                  mplier <= {{2{mplier[EXT]}}, mplier[EXT:2]};
                  count  <= count + 1'b1;
                  if (count == CNTW'(LAST)) begin
                     state   <= DONE;
                     ready_q <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  acc   <= '0;
                  count <= '0;
               end
            end
            DONE: begin
               state   <= IDLE;
               ready_q <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready      = ready_q;
   assign bus.mul_result = acc[2*XLEN-1:0];
endmodule

// File: tb/tb_multi_cycle_mul.sv
// Self-checking bench for multi_cycle_mul: directed vector table, hand-written
// handshake corner cases, and random operations against a wide-arithmetic model.
module tb_multi_cycle_mul;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   multi_cycle_mul_if #(.XLEN(64)) bus ();

   multi_cycle_mul #(.XLEN(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [63:0]  rs1;
      logic [63:0]  rs2;
      logic         s1;
      logic         s2;
      logic         m32;
      logic [127:0] expected;
      int           latency;
   } vec_t;

   vec_t vecs [10];

   // Reference: extend each operand to 128 bits and keep the low half of the product.
   function automatic logic [127:0] refProduct(input logic [63:0] a, input logic [63:0] b,
                                               input logic sa, input logic sb, input logic m32);
      logic [127:0] ea;
      logic [127:0] eb;
      if (m32) begin
         ea = {{96{sa & a[31]}}, a[31:0]};
         eb = {{96{sb & b[31]}}, b[31:0]};
      end else begin
         ea = {{64{sa & a[63]}}, a};
         eb = {{64{sb & b[63]}}, b};
      end
      return ea * eb;
   endfunction

   function automatic int refLatency(input logic [63:0] a, input logic [63:0] b, input logic m32);
      logic zero;
      zero = m32 ? (a[31:0] == 32'd0 || b[31:0] == 32'd0) : (a == 64'd0 || b == 64'd0);
      return zero ? 1 : 34;
   endfunction

   function automatic logic [63:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return 64'd1;
         2:       return 64'hFFFF_FFFF_FFFF_FFFF;
         3:       return 64'h8000_0000_0000_0000;
         4:       return {$urandom, 32'h8000_0000};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
      end
   endtask

   // Counts edges from the accepting edge (edge 1) until ready is seen.
   task automatic waitReady(output logic [127:0] result, output int lat);
      bit got;
      got    = 1'b0;
      lat    = 0;
      result = '0;
      while (!got && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1) begin
            bus.rs1_data = {$urandom, $urandom};
            bus.rs2_data = {$urandom, $urandom};
         end
         if (bus.ready === 1'b1) got = 1'b1;
      end
      result    = bus.mul_result;
      bus.valid = 1'b0;
      if (!got) checkOutput("ready_timeout", 128'd0, 128'd1);
   endtask

   task automatic applyStimulus(input logic [63:0] rs1, input logic [63:0] rs2,
                                input logic s1, input logic s2, input logic m32,
                                output logic [127:0] result, output int lat);
      @(negedge clk);
      bus.rs1_data   = rs1;
      bus.rs2_data   = rs2;
      bus.rs1_signed = s1;
      bus.rs2_signed = s2;
      bus.mul_32     = m32;
      bus.valid      = 1'b1;
      waitReady(result, lat);
   endtask

   task automatic runOp(input string name, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic s1, input logic s2, input logic m32,
                        input logic [127:0] expected, input int exp_lat);
      logic [127:0] result;
      int           lat;
      applyStimulus(rs1, rs2, s1, s2, m32, result, lat);
      checkOutput({name, "_result"}, result, expected);
      checkOutput({name, "_latency"}, 128'(lat), 128'(exp_lat));
      @(negedge clk);
      checkOutput({name, "_ready_pulse"}, 128'(bus.ready), 128'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1, "[TB] simulation hung");
   end

   initial begin
      logic [127:0] result;
      logic [63:0]  a;
      logic [63:0]  b;
      logic         sa;
      logic         sb;
      logic         m32;
      int           lat;
      bit           seen;

      vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0,
                  128'hFFFFFFFFFFFFFFFE_0000000000000001, 34};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
                  128'h0000000000000000_0000000000000001, 34};
      vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0,
                  128'h4000000000000000_0000000000000000, 34};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
                  128'hFFFFFFFFFFFFFFFF_0000000000000001, 34};
      vecs[4] = '{64'hDEAD_BEEF_8000_0000, 64'h1234_5678_0000_0002, 1'b1, 1'b1, 1'b1,
                  128'hFFFFFFFFFFFFFFFF_FFFFFFFF00000000, 34};
      vecs[5] = '{64'h0000_0000_0000_1234, 64'h0, 1'b0, 1'b0, 1'b0, 128'd0, 1};
      vecs[6] = '{64'hFFFF_FFFF_0000_0000, 64'd5, 1'b1, 1'b1, 1'b1, 128'd0, 1};
      vecs[7] = '{64'd7, 64'd6, 1'b0, 1'b0, 1'b0, 128'd42, 34};
      vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1, 1'b0,
                  128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFF1, 34};
      vecs[9] = '{64'hAAAA_AAAA_FFFF_FFFF, 64'h5555_5555_FFFF_FFFF, 1'b0, 1'b0, 1'b1,
                  128'h0000000000000000_FFFFFFFE00000001, 34};

      bus.valid      = 1'b0;
      bus.rs1_signed = 1'b0;
      bus.rs2_signed = 1'b0;
      bus.mul_32     = 1'b0;
      bus.rs1_data   = '0;
      bus.rs2_data   = '0;
      rst            = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", 128'(bus.ready), 128'd0);
      checkOutput("reset_result", bus.mul_result, 128'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].s1, vecs[i].s2,
               vecs[i].m32, vecs[i].expected, vecs[i].latency);
      end

      // Abort: dropping valid mid-operation must never produce ready.
      @(negedge clk);
      bus.rs1_data = 64'd3; bus.rs2_data = 64'd5;
      bus.rs1_signed = 1'b0; bus.rs2_signed = 1'b0; bus.mul_32 = 1'b0;
      bus.valid = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      bus.valid = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.ready === 1'b1) seen = 1'b1;
      end
      checkOutput("abort_no_ready", 128'(seen), 128'd0);
      runOp("after_abort", 64'd7, 64'd6, 1'b0, 1'b0, 1'b0, 128'd42, 34);

      // Reset mid-operation, with valid still high at the reset edge.
      @(negedge clk);
      bus.rs1_data = 64'd3; bus.rs2_data = 64'd5; bus.valid = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midop_reset_ready", 128'(bus.ready), 128'd0);
      checkOutput("midop_reset_result", bus.mul_result, 128'd0);
      bus.valid = 1'b0;
      rst = 1'b0;
      runOp("after_reset", 64'd9, 64'd11, 1'b0, 1'b0, 1'b0, 128'd99, 34);

      // Back-to-back: valid held through the early-out DONE cycle.
      @(negedge clk);
      bus.rs1_data = 64'h1234; bus.rs2_data = 64'd0; bus.valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_zero_ready", 128'(bus.ready), 128'd1);
      checkOutput("b2b_zero_result", bus.mul_result, 128'd0);
      bus.rs1_data = 64'd7; bus.rs2_data = 64'd6;
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_idle_ready", 128'(bus.ready), 128'd0);
      waitReady(result, lat);
      checkOutput("b2b_second_result", result, 128'd42);
      checkOutput("b2b_second_latency", 128'(lat), 128'd34);
      @(negedge clk);
      checkOutput("b2b_ready_pulse", 128'(bus.ready), 128'd0);

      for (int i = 0; i < 40; i++) begin
         a   = pickOperand();
         b   = pickOperand();
         sa  = 1'($urandom_range(0, 1));
         sb  = 1'($urandom_range(0, 1));
         m32 = ($urandom_range(0, 3) == 0);
         runOp($sformatf("rand%0d", i), a, b, sa, sb, m32,
               refProduct(a, b, sa, sb, m32), refLatency(a, b, m32));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
